// File: rtl/mpu_regions_pkg.sv
// Shared core types for the memory protection unit: privilege levels,
// per-region permission record and fault cause codes.
package mpu_regions_pkg;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } priv_e;

   typedef struct packed {
      logic en;
      logic r;
      logic w;
      logic x;
      logic u;
      logic lock;
   } mpu_perm_t;

   typedef enum logic [2:0] {
      CAUSE_NONE  = 3'd0,
      CAUSE_EXEC  = 3'd1,
      CAUSE_LOAD  = 3'd2,
      CAUSE_STORE = 3'd3,
      CAUSE_MULTI = 3'd4
   } mpu_cause_e;

   // Index width that stays legal when only one region exists.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mpu_region_match.sv
// Single-region hit detector: enabled and address inside the inclusive
// [base, limit] window, compared unsigned.
module mpu_region_match #(
   parameter int AW = 32
) (
   input  logic          i_en,
   input  logic [AW-1:0] i_base,
   input  logic [AW-1:0] i_limit,
   input  logic [AW-1:0] i_addr,
   output logic          o_match
);

   assign o_match = i_en && (i_addr >= i_base) && (i_addr <= i_limit);

endmodule

// File: rtl/mpu_regions.sv
// Region-based memory protection check with one-cycle response latency,
// lockable region entries and a sticky first-fault capture register.
module mpu_regions
   import mpu_regions_pkg::*;
#(
   parameter int            NREG     = 8,
   parameter int            AW       = 32,
   parameter logic [AW-1:0] RAM_BASE = 32'h8000_0000,
   parameter logic [AW-1:0] RAM_SIZE = 32'h1000_0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_we,
   input  logic [idx_w(NREG)-1:0]    cfg_idx,
   input  logic [AW-1:0]             cfg_base,
   input  logic [AW-1:0]             cfg_limit,
   input  mpu_perm_t                 cfg_perm,
   input  logic                      req_valid,
   input  logic [AW-1:0]             addr,
   input  logic                      is_fetch,
   input  logic                      is_load,
   input  logic                      is_store,
   input  priv_e                     cur_priv,
   output logic                      rsp_valid,
   output logic                      allow,
   output logic                      fault_exec,
   output logic                      fault_load,
   output logic                      fault_store,
   output logic                      fault_pending,
   output logic [AW-1:0]             fault_addr,
   output mpu_cause_e                fault_cause,
   output logic [$clog2(NREG+1)-1:0] fault_region,
   output logic                      fault_ovf,
   input  logic                      fault_clr
);

   localparam int IW = idx_w(NREG);
   localparam int RW = $clog2(NREG+1);

   mpu_perm_t     r_perm  [NREG];
   logic [AW-1:0] r_base  [NREG];
   logic [AW-1:0] r_limit [NREG];

   logic            r_rsp_valid;
   logic            r_allow;
   logic            r_fault_exec;
   logic            r_fault_load;
   logic            r_fault_store;
   logic            r_fault_pending;
   logic            r_fault_ovf;
   logic [AW-1:0]   r_fault_addr;
   mpu_cause_e      r_fault_cause;
   logic [RW-1:0]   r_fault_region;

   logic [NREG-1:0] w_match;
   logic            w_hit;
   logic [RW-1:0]   w_hit_idx;
   mpu_perm_t       w_hit_perm;
   logic            w_in_ram;
   logic [1:0]      w_kind_cnt;
   logic            w_multi;
   logic            w_allow;
   mpu_cause_e      w_cause;
   logic            w_deny;

   // Region table; a stored lock freezes the entry until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_perm[i]  <= '0;
            r_base[i]  <= '0;
            r_limit[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (cfg_we && (cfg_idx == IW'(i)) && !r_perm[i].lock) begin
               r_perm[i]  <= cfg_perm;
               r_base[i]  <= cfg_base;
               r_limit[i] <= cfg_limit;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_match
         mpu_region_match #(.AW(AW)) u_match (
            .i_en    (r_perm[gi].en),
            .i_base  (r_base[gi]),
            .i_limit (r_limit[gi]),
            .i_addr  (addr),
            .o_match (w_match[gi])
         );
      end
   endgenerate

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = RW'(NREG);
      w_hit_perm = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            w_hit      = 1'b1;
            w_hit_idx  = RW'(i);
            w_hit_perm = r_perm[i];
         end
      end
   end

   // Offset form avoids overflow when the window touches the top of memory.
   assign w_in_ram   = (addr >= RAM_BASE) && ((addr - RAM_BASE) < RAM_SIZE);
   assign w_kind_cnt = 2'(is_fetch) + 2'(is_load) + 2'(is_store);
   assign w_multi    = (w_kind_cnt != 2'd1);

   always_comb begin
      w_allow = 1'b0;
      if (w_multi) begin
         w_allow = 1'b0;
      end else if (w_hit) begin
         if (!w_hit_perm.lock && (cur_priv == PRIV_M)) begin
            w_allow = 1'b1;
         end else begin
            w_allow = ((is_fetch && w_hit_perm.x) ||
                       (is_load  && w_hit_perm.r) ||
                       (is_store && w_hit_perm.w)) &&
                      (w_hit_perm.u || (cur_priv != PRIV_U));
         end
      end else if (is_fetch && w_in_ram) begin
         w_allow = 1'b0;
      end else begin
         w_allow = (cur_priv == PRIV_M);
      end
   end

   always_comb begin
      w_cause = CAUSE_STORE;
      if (w_multi)       w_cause = CAUSE_MULTI;
      else if (is_fetch) w_cause = CAUSE_EXEC;
      else if (is_load)  w_cause = CAUSE_LOAD;
   end

   assign w_deny = req_valid && !w_allow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid   <= 1'b0;
         r_allow       <= 1'b0;
         r_fault_exec  <= 1'b0;
         r_fault_load  <= 1'b0;
         r_fault_store <= 1'b0;
      end else begin
         r_rsp_valid   <= req_valid;
         r_allow       <= req_valid && w_allow;
         r_fault_exec  <= w_deny && is_fetch;
         r_fault_load  <= w_deny && is_load;
         r_fault_store <= w_deny && is_store;
      end
   end

   // Capture lands on the same edge as the response, so the captured
   // fields are visible alongside the denial that produced them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fault_pending <= 1'b0;
         r_fault_ovf     <= 1'b0;
         r_fault_addr    <= '0;
         r_fault_cause   <= CAUSE_NONE;
         r_fault_region  <= '0;
      end else if (w_deny && (!r_fault_pending || fault_clr)) begin
         r_fault_pending <= 1'b1;
         r_fault_ovf     <= 1'b0;
         r_fault_addr    <= addr;
         r_fault_cause   <= w_cause;
         r_fault_region  <= w_hit_idx;
      end else if (w_deny) begin
         r_fault_ovf     <= 1'b1;
      end else if (fault_clr) begin
         r_fault_pending <= 1'b0;
         r_fault_ovf     <= 1'b0;
      end
   end

   assign rsp_valid     = r_rsp_valid;
   assign allow         = r_allow;
   assign fault_exec    = r_fault_exec;
   assign fault_load    = r_fault_load;
   assign fault_store   = r_fault_store;
   assign fault_pending = r_fault_pending;
   assign fault_ovf     = r_fault_ovf;
   assign fault_addr    = r_fault_addr;
   assign fault_cause   = r_fault_cause;
   assign fault_region  = r_fault_region;

endmodule

// File: doc/mpu_regions.md
MPU_REGIONS -- requirements
Module: mpu_regions

Interface
REQ-001 Parameter NREG, default 8, number of programmable regions (1..16).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter RAM_BASE, default 32'h8000_0000, base of the background no-execute RAM window.
REQ-004 Parameter RAM_SIZE, default 32'h1000_0000, size of that window in bytes.
REQ-005 Clock and reset: single clock clk; reset is asynchronous and active-low, named rst_n.
REQ-006 clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 cfg_we  in  1  region write strobe; cfg_idx  in  $clog2(NREG)  region index.
REQ-008 cfg_base  in  AW  inclusive low bound; cfg_limit  in  AW  inclusive high bound.
REQ-009 cfg_perm  in  mpu_perm_t  {en, r, w, x, u, lock}.
REQ-010 req_valid  in  1  access check request.
REQ-011 addr  in  AW  access address.
REQ-012 is_fetch, is_load, is_store  in  1 each  access kind.
REQ-013 cur_priv  in  priv_e  current privilege.
REQ-014 rsp_valid  out  1  response strobe.
REQ-015 allow  out  1  access permitted.
REQ-016 fault_exec, fault_load, fault_store  out  1 each  per-kind denial.
REQ-017 fault_pending  out  1  sticky capture flag.
REQ-018 fault_addr  out  AW  captured address.
REQ-019 fault_cause  out  mpu_cause_e  captured cause.
REQ-020 fault_region  out  $clog2(NREG+1)  matched region, or NREG when no region matched.
REQ-021 fault_ovf  out  1  sticky flag: a further fault occurred while fault_pending was set.
REQ-022 fault_clr  in  1  clears the capture state.

Function
REQ-023 Response latency is exactly one cycle: rsp_valid, allow and fault_* reflect the req_valid request of the previous cycle.
REQ-024 When rsp_valid=0, allow and all fault_* outputs SHALL be 0.
REQ-025 Region i matches when en=1 and cfg_base<=addr<=cfg_limit, compared unsigned over full AW bits.
REQ-026 When several regions match, the lowest index wins.
REQ-027 If a matched region has lock=0 and cur_priv==PRIV_M, the access is allowed.
REQ-028 In all other matched cases the access is allowed only if: the x/r/w bit for the kind is set, and (u=1 or cur_priv!=PRIV_U).
REQ-029 Locked regions bind PRIV_M.
REQ-030 With no region matched, a fetch inside [RAM_BASE, RAM_BASE+RAM_SIZE) is denied at every privilege.
REQ-031 With no region matched, any other access is allowed for PRIV_M and denied for PRIV_S and PRIV_U.
REQ-032 If zero or more than one of the is_* inputs is set, the access is denied with cause CAUSE_MULTI; each asserted is_* raises its fault_* output.
REQ-033 A denial asserts the fault_* output matching the access kind, and allow=0.
REQ-034 A config write takes effect for requests presented the cycle after cfg_we.
REQ-035 A request presented in the same cycle as cfg_we is checked against the old configuration.
REQ-036 A write to a region whose stored lock=1 is ignored; the lock is cleared only by reset.
REQ-037 A write setting lock=1 stores all fields and locks them.
REQ-038 Capture: on a denied response with fault_pending=0, fault_addr, fault_cause and fault_region are loaded and fault_pending is set.
REQ-039 On a denied response with fault_pending=1, the captured fields are held and fault_ovf is set.
REQ-040 fault_clr clears fault_pending and fault_ovf.
REQ-041 If fault_clr coincides with a new denial, the new fault is captured, fault_pending=1 and fault_ovf=0.

Reset
REQ-042 Asynchronous assertion of rst_n SHALL clear all region entries (en=0, lock=0, bounds 0).
REQ-043 Reset SHALL force rsp_valid, allow, all fault_* outputs, fault_pending and fault_ovf to 0.
REQ-044 Reset SHALL force fault_addr to 0, fault_cause to CAUSE_NONE and fault_region to 0.
REQ-045 A request in flight at reset produces no response after reset release.

Structure
REQ-046 mpu_perm_t and mpu_cause_e {CAUSE_NONE, CAUSE_EXEC, CAUSE_LOAD, CAUSE_STORE, CAUSE_MULTI} SHALL live in the shared core package alongside priv_e.
REQ-047 One sub-module, mpu_region_match, performs a single region's enable/bounds compare and is instantiated NREG times.

Verification
REQ-048 Reset, no regions, PRIV_S fetch at 32'h8000_0000 -> next cycle rsp_valid=1, allow=0, fault_exec=1, fault_cause=CAUSE_EXEC, fault_region=NREG.
REQ-049 Region0 0x8000_0000..0x8000_0FFF, perms r,w,x,u,en; region1 the same range, perm r only; PRIV_U store at 0x8000_0010 -> allow=1 (region0 wins by priority).
REQ-050 Region2 locked with r only; PRIV_M store in range -> fault_store=1; later rewrite of region2 with w=1 -> store still faults.
REQ-051 Two consecutive denials without fault_clr -> fault_addr holds the first address, fault_ovf=1; fault_clr in the same cycle as a third denial -> third address captured, fault_ovf=0.
REQ-052 cfg_we and req_valid in the same cycle on the same region -> response reflects the old permissions; the next request reflects the new ones.
